// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_pkg
// Purpose  : Shared sizing helpers for the HDMI sliding-window path.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

    // Samples per pixel times bits per sample (PIX_W).
    function automatic int pix_width(input int ch, input int data_w);
        return ch * data_w;
    endfunction

    // Offset of the window centre from the newest slot (HALF_K).
    function automatic int half_kernel(input int ksize);
        return (ksize - 1) / 2;
    endfunction

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int slot_idx(input int r, input int c, input int ksize);
        return r * ksize + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_line_ram.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_line_ram
// Purpose  : Simple dual-port line buffer, 1-cycle synchronous read, write-first.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_line_ram #(
    parameter int DEPTH = 1920,
    parameter int WIDTH = 24,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_wr_en && (i_wr_addr == i_rd_addr)) o_rd_data <= i_wr_data;
        else                                     o_rd_data <= r_mem[i_rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/hdmi_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_window_gen
// Purpose  : KSIZE x KSIZE sliding-window generator with 2-cycle aligned syncs.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_window_gen
    import hdmi_pkg::*;
#(
    parameter int KSIZE  = 5,
    parameter int DATA_W = 8,
    parameter int CH     = 3,
    parameter int LINE_W = 1920,
    parameter bit VS_POL = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CH*DATA_W-1:0]             rx_pix,
    input  logic                             rx_dv,
    input  logic                             rx_hs,
    input  logic                             rx_vs,
    output logic [KSIZE*KSIZE*CH*DATA_W-1:0] win_pix,
    output logic                             win_dv,
    output logic                             win_hs,
    output logic                             win_vs,
    output logic                             win_edge,
    output logic                             win_ovf
);

    localparam int PIX_W = pix_width(CH, DATA_W);
    localparam int AW    = clog2(LINE_W);
    localparam int RW    = clog2(KSIZE);
    localparam int NRAM  = KSIZE - 1;

    localparam logic [AW-1:0] C_COL_MAX  = AW'(LINE_W - 1);
    localparam logic [AW-1:0] C_COL_FULL = AW'(KSIZE - 1);
    localparam logic [RW-1:0] C_ROW_MAX  = RW'(KSIZE - 1);

    logic [PIX_W-1:0] r_pix_d1;
    logic             r_dv_d1, r_hs_d1, r_vs_d1, r_edge_d1, r_we_d1;
    logic [AW-1:0]    r_addr_d1;
    logic [AW-1:0]    r_col;
    logic             r_col_sat;
    logic [RW-1:0]    r_row;
    logic             r_ovf;

    logic             w_dv_fall, w_vs_assert, w_edge;
    logic [PIX_W-1:0] w_rd  [NRAM];
    logic [PIX_W-1:0] w_wr  [NRAM];
    logic [PIX_W-1:0] w_col [KSIZE];
    logic [PIX_W-1:0] r_win [KSIZE][KSIZE];

    // r_dv_d1 / r_vs_d1 double as the previous-cycle values for edge detection.
    assign w_dv_fall   = r_dv_d1 & ~rx_dv;
    assign w_vs_assert = (rx_vs == VS_POL) && (r_vs_d1 != VS_POL);
    assign w_edge      = (r_row < C_ROW_MAX) || (r_col < C_COL_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_d1  <= '0;
            r_dv_d1   <= 1'b0;
            r_hs_d1   <= 1'b0;
            r_vs_d1   <= 1'b0;
            r_edge_d1 <= 1'b0;
            r_we_d1   <= 1'b0;
            r_addr_d1 <= '0;
            r_col     <= '0;
            r_col_sat <= 1'b0;
            r_row     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pix_d1  <= rx_pix;
            r_dv_d1   <= rx_dv;
            r_hs_d1   <= rx_hs;
            r_vs_d1   <= rx_vs;
            r_edge_d1 <= w_edge;
            r_we_d1   <= rx_dv & ~r_col_sat;
            r_addr_d1 <= r_col;

            // r_col_sat marks that column LINE_W-1 has already been consumed.
            if (rx_dv) begin
                if (r_col == C_COL_MAX) r_col_sat <= 1'b1;
                else                    r_col     <= r_col + AW'(1);
            end else if (w_dv_fall) begin
                r_col     <= '0;
                r_col_sat <= 1'b0;
            end

            if (w_vs_assert)
                r_row <= '0;
            else if (w_dv_fall && (r_row != C_ROW_MAX))
                r_row <= r_row + RW'(1);

            if (w_vs_assert)
                r_ovf <= 1'b0;
            else if (rx_dv && r_col_sat)
                r_ovf <= 1'b1;
        end
    end

    always_comb begin
        w_wr[0] = r_pix_d1;
        for (int k = 1; k < NRAM; k++) w_wr[k] = w_rd[k-1];
    end

    generate
        for (genvar k = 0; k < NRAM; k++) begin : g_line_ram
            hdmi_line_ram #(
                .DEPTH (LINE_W),
                .WIDTH (PIX_W),
                .AW    (AW)
            ) u_ram (
                .clk       (clk),
                .i_wr_en   (r_we_d1),
                .i_wr_addr (r_addr_d1),
                .i_wr_data (w_wr[k]),
                .i_rd_addr (r_col),
                .o_rd_data (w_rd[k])
            );
        end
    endgenerate

    // RAM k holds the line k+1 rows above the current one.
    always_comb begin
        for (int r = 0; r < KSIZE - 1; r++) w_col[r] = w_rd[KSIZE-2-r];
        w_col[KSIZE-1] = r_pix_d1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_dv   <= 1'b0;
            win_hs   <= 1'b0;
            win_vs   <= 1'b0;
            win_edge <= 1'b0;
            win_ovf  <= 1'b0;
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) r_win[r][c] <= '0;
            end
        end else begin
            win_dv   <= r_dv_d1;
            win_hs   <= r_hs_d1;
            win_vs   <= r_vs_d1;
            win_edge <= r_edge_d1;
            win_ovf  <= r_ovf;
            if (r_dv_d1) begin
                for (int r = 0; r < KSIZE; r++) begin
                    for (int c = 0; c < KSIZE - 1; c++) r_win[r][c] <= r_win[r][c+1];
                    r_win[r][KSIZE-1] <= w_col[r];
                end
            end
        end
    end

    generate
        for (genvar r = 0; r < KSIZE; r++) begin : g_win_row
            for (genvar c = 0; c < KSIZE; c++) begin : g_win_col
                assign win_pix[slot_idx(r, c, KSIZE)*PIX_W +: PIX_W] = r_win[r][c];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hdmi_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_window_gen
// Purpose  : Scoreboard bench for hdmi_window_gen against a line-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_window_gen;

    localparam int K      = 5;
    localparam int DW     = 8;
    localparam int NCH    = 3;
    localparam int LW     = 16;
    localparam int PW     = NCH * DW;
    localparam int SLOTS  = K * K;
    localparam bit VS_POL = 1'b1;

    typedef struct packed {
        logic [31:0]         due;
        logic                dv;
        logic                hs;
        logic                vs;
        logic                ovf;
        logic                edg;
        logic [SLOTS-1:0]    mask;
        logic [SLOTS*PW-1:0] pix;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PW-1:0]     rx_pix = '0;
    logic              rx_dv = 1'b0, rx_hs = 1'b0, rx_vs = 1'b0;
    logic [SLOTS*PW-1:0] win_pix;
    logic              win_dv, win_hs, win_vs, win_edge, win_ovf;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    // Reference model: counts since vsync/line start plus the last K-1 finished lines.
    int            m_row = 0, m_n = 0, hist_cnt = 0;
    bit            m_prev_dv = 0, m_prev_vs = 0, m_ovf = 0;
    logic [PW-1:0] cur_line [LW];
    logic [PW-1:0] hist_pix [K-1][LW];
    int            hist_len [K-1];

    hdmi_window_gen #(
        .KSIZE (K), .DATA_W (DW), .CH (NCH), .LINE_W (LW), .VS_POL (VS_POL)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .rx_pix (rx_pix), .rx_dv (rx_dv), .rx_hs (rx_hs), .rx_vs (rx_vs),
        .win_pix (win_pix), .win_dv (win_dv), .win_hs (win_hs), .win_vs (win_vs),
        .win_edge (win_edge), .win_ovf (win_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_dv"},   32'(win_dv),   0);
        check({nm, "_hs"},   32'(win_hs),   0);
        check({nm, "_vs"},   32'(win_vs),   0);
        check({nm, "_edge"}, 32'(win_edge), 0);
        check({nm, "_ovf"},  32'(win_ovf),  0);
        checks++;
        if (win_pix !== '0) begin
            failures++;
            $display("FAIL %s_pix: got nonzero window expected 0 (cyc %0d)", nm, cyc);
        end
    endtask

    task automatic drive(input logic [PW-1:0] pix, input logic dv, input logic hs, input logic vs);
        exp_t          e;
        int            col, dr, cc, s;
        bit            vs_as, ok;
        logic [PW-1:0] val;
        rx_pix = pix; rx_dv = dv; rx_hs = hs; rx_vs = vs;
        vs_as  = (vs == VS_POL) && (m_prev_vs != VS_POL);
        e      = '0;
        e.due  = 32'(cyc + 2);
        e.dv   = dv; e.hs = hs; e.vs = vs;
        if (dv) begin
            m_n++;
            col = (m_n > LW) ? LW - 1 : m_n - 1;
            if (m_n <= LW) cur_line[col] = pix;
            e.edg = (m_row < K - 1) || (col < K - 1);
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    dr = K - 1 - r; cc = col - (K - 1 - c); s = r * K + c;
                    ok = 0; val = '0;
                    if (r == K - 1 && c == K - 1) begin
                        ok = 1; val = pix;
                    end else if (m_n <= LW && cc >= 0) begin
                        if (dr == 0) begin
                            ok = 1; val = cur_line[cc];
                        end else if (!e.edg && hist_cnt >= dr) begin
                            ok = 1;
                            for (int j = 0; j < dr; j++) if (hist_len[j] <= cc) ok = 0;
                            val = hist_pix[dr-1][cc];
                        end
                    end
                    e.mask[s] = ok;
                    if (ok) e.pix[s*PW +: PW] = val;
                end
            end
        end
        if (vs_as)                 m_ovf = 0;
        else if (dv && m_n > LW)   m_ovf = 1;
        e.ovf = m_ovf;
        if (m_prev_dv && !dv) begin
            for (int j = K - 2; j > 0; j--) begin
                for (int x = 0; x < LW; x++) hist_pix[j][x] = hist_pix[j-1][x];
                hist_len[j] = hist_len[j-1];
            end
            for (int x = 0; x < LW; x++) hist_pix[0][x] = cur_line[x];
            hist_len[0] = (m_n > LW) ? LW : m_n;
            if (hist_cnt < K - 1) hist_cnt++;
            m_n = 0;
            m_row++;
        end
        if (vs_as) m_row = 0;
        m_prev_dv = dv; m_prev_vs = vs;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic vsync();
        for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b0, VS_POL);
        for (int i = 0; i < 2; i++) drive('0, 1'b0, 1'b0, ~VS_POL);
    endtask

    task automatic mid_reset(input logic [PW-1:0] pix);
        rx_pix = pix; rx_dv = 1'b1; rx_hs = 1'b0; rx_vs = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        sb.delete();
        m_row = 0; m_n = 0; m_prev_dv = 0; m_prev_vs = 0; m_ovf = 0; hist_cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic line(input int w, input int row, input bit rnd, input int rst_col);
        logic [PW-1:0] p;
        logic [7:0]    r8, c8;
        for (int c = 0; c < w; c++) begin
            r8 = 8'(row); c8 = 8'(c);
            p  = rnd ? PW'($urandom) : {r8, c8, r8 ^ c8};
            if (c == rst_col) mid_reset(p);
            else              drive(p, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic frame(input int w, input int h, input bit rnd, input int rst_row, input int rst_col);
        vsync();
        for (int r = 0; r < h; r++) begin
            line(w, r, rnd, (r == rst_row) ? rst_col : -1);
            blank($urandom_range(2, 5));
        end
    endtask

    exp_t me;
    int   bad;
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due <= 32'(cyc)) begin
                me = sb.pop_front();
                if (me.due < 32'(cyc)) begin
                    checks++; failures++;
                    $display("FAIL sb_late: got cyc %0d expected cyc %0d", cyc, me.due);
                end else begin
                    check("win_dv",  32'(win_dv),  32'(me.dv));
                    check("win_hs",  32'(win_hs),  32'(me.hs));
                    check("win_vs",  32'(win_vs),  32'(me.vs));
                    check("win_ovf", 32'(win_ovf), 32'(me.ovf));
                    if (me.dv) begin
                        check("win_edge", 32'(win_edge), 32'(me.edg));
                        bad = -1;
                        for (int s = 0; s < SLOTS; s++)
                            if (bad < 0 && me.mask[s] && (win_pix[s*PW +: PW] !== me.pix[s*PW +: PW]))
                                bad = s;
                        checks++;
                        if (bad >= 0) begin
                            failures++;
                            $display("FAIL win_pix slot %0d: got %h expected %h (cyc %0d)",
                                     bad, win_pix[bad*PW +: PW], me.pix[bad*PW +: PW], cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;
        idle(4);
        drive(24'hABCDEF, 1'b1, 1'b0, 1'b0);
        idle(4);
        frame(16, 8, 1'b0, -1, -1);
        for (int f = 0; f < 3; f++) frame($urandom_range(5, 16), 8, 1'b1, -1, -1);
        // 20-pixel line overflows LW=16; the following 16-pixel line stays flagged
        vsync();
        line(20, 0, 1'b1, -1); blank(4);
        line(16, 1, 1'b1, -1); blank(4);
        frame(16, 8, 1'b1, -1, -1);
        frame(16, 8, 1'b1, 5, 7);
        frame(12, 7, 1'b1, -1, -1);
        idle(6);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++; failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
